multi_cycle_controller: RTL and testbench
=========================================

Name: multi_cycle_controller

Overview:
Main control FSM for multi_cycle_cpu. It sequences the shared ALU, the unified instruction/data memory port, the IR, the PC and the register file over multiple cycles per instruction. It decodes opcode/funct and stalls on a memory ready handshake. Supported instructions: R-type add/sub/and/or/slt, lw, sw, beq, addi, j.

Parameters:
STATE_W, 4, width of state_debug / state register

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted = 0)
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, same cycle
mem_ready  in  1  memory has completed the current read/write this cycle
pc_en  out  1  PC load enable
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
mem_write  out  1  memory write strobe
ir_write  out  1  IR load enable
reg_dst  out  1  write register select: 0 = rt, 1 = rd
mem_to_reg  out  1  write data select: 0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  ALU A select: 0 = PC, 1 = A reg
alu_src_b  out  2  ALU B select: 00 = B reg, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
alu_control  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
retire  out  1  one-cycle pulse in the final cycle of each instruction
illegal  out  1  one-cycle pulse in Decode for an unsupported opcode or funct
state_debug  out  STATE_W  current state encoding

Behaviour:
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11. Codes 12–15 return to FETCH on the next edge.
- Outputs are decoded from the state only; pc_en in BRANCH also depends on zero. Any output not listed for a state is 0 (alu_control defaults to 010).
- While reset = 0: state = FETCH and every output is forced to 0, including state_debug = 0. After release, FETCH behaves normally from the first edge. Reset mid-instruction abandons the instruction with no write strobes issued.
- FETCH: iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00. ir_write and pc_en assert only when mem_ready=1. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC (funct must be legal)
  - 100011 -> MEMADR
  - 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - Any other opcode, or R-type with an unsupported funct: illegal=1, retire=0, next state FETCH; the instruction is treated as a NOP.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Hold while mem_ready=0, then go to MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1, retire=1. Next FETCH.
- MEMWR: iord=1, mem_write=1 held continuously until the mem_ready=1 cycle. retire=1 in that cycle. Next FETCH.
- EXEC: alu_src_a=1, alu_src_b=00. alu_control by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Next ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1, retire=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=zero, retire=1. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add. Next ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1, retire=1. Next FETCH.
- JUMP: pc_src=10, pc_en=1, retire=1. Next FETCH.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.
- No two write strobes (reg_write, mem_write, ir_write) are ever asserted in the same cycle.

Test Plan:
- Reset held low with mem_ready=1 -> all outputs 0. Release -> state_debug=0, then pc_en=ir_write=1 in the first FETCH cycle.
- add (opcode 0, funct 100000), mem_ready=1 -> states 0,1,6,7. alu_control=010 in EXEC. reg_write=reg_dst=retire=1 in cycle 4 only.
- lw with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4 (7 cycles). mem_to_reg=1 and reg_write=1 only in MEMWB.
- beq with zero=1, then beq with zero=0 -> pc_en=1/pc_src=01 in BRANCH for the first, pc_en=0 for the second. Both take 3 cycles with retire pulsing once.
- sw with mem_ready=0 for 3 cycles in MEMWR -> mem_write=1 for 4 consecutive cycles, iord=1 throughout, retire only in the final cycle.
- Opcode 111111, then reset asserted during ADDIEX of an addi -> first case: illegal pulses in DECODE, then FETCH. Second case: immediately state_debug=0, all outputs 0, and reg_write never asserted.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// Main control FSM for the multi-cycle CPU: sequences the shared ALU, the unified
// memory port, IR, PC and register file, stalling on the memory ready handshake.
module multi_cycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [2:0]         alu_control,
  output logic [1:0]         pc_src,
  output logic               retire,
  output logic               illegal,
  output logic [STATE_W-1:0] state_debug
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_r;
  state_t next_state_s;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_legal = 1'b1;
      default:                                               funct_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_alu = ALU_ADD;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and control decode; everything is held at 0 while reset is asserted
  always_comb begin
    next_state_s = FETCH;
    pc_en        = 1'b0;
    iord         = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    alu_control  = ALU_ADD;
    pc_src       = 2'b00;
    retire       = 1'b0;
    illegal      = 1'b0;
    state_debug  = '0;
    if (!reset) begin
      alu_control  = 3'b000;
      next_state_s = FETCH;
    end else begin
      state_debug = STATE_W'(state_r);
      case (state_r)
        FETCH: begin
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
          next_state_s = mem_ready ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_RTYPE: begin
              if (funct_legal(funct)) begin
                next_state_s = EXEC;
              end else begin
                illegal      = 1'b1;
                next_state_s = FETCH;
              end
            end
            OP_LW, OP_SW: next_state_s = MEMADR;
            OP_BEQ:       next_state_s = BRANCH;
            OP_ADDI:      next_state_s = ADDIEX;
            OP_J:         next_state_s = JUMP;
            default: begin
              illegal      = 1'b1;
              next_state_s = FETCH;
            end
          endcase
        end
        MEMADR: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          next_state_s = (opcode == OP_SW) ? MEMWR : MEMRD;
        end
        MEMRD: begin
          iord         = 1'b1;
          next_state_s = mem_ready ? MEMWB : MEMRD;
        end
        MEMWB: begin
          mem_to_reg   = 1'b1;
          reg_write    = 1'b1;
          retire       = 1'b1;
          next_state_s = FETCH;
        end
        MEMWR: begin
          // Strobe stays up until the memory accepts the write
          iord         = 1'b1;
          mem_write    = 1'b1;
          retire       = mem_ready;
          next_state_s = mem_ready ? FETCH : MEMWR;
        end
        EXEC: begin
          alu_src_a    = 1'b1;
          alu_control  = funct_alu(funct);
          next_state_s = ALUWB;
        end
        ALUWB: begin
          reg_dst      = 1'b1;
          reg_write    = 1'b1;
          retire       = 1'b1;
          next_state_s = FETCH;
        end
        BRANCH: begin
          alu_src_a    = 1'b1;
          alu_control  = ALU_SUB;
          pc_src       = 2'b01;
          pc_en        = zero;
          retire       = 1'b1;
          next_state_s = FETCH;
        end
        ADDIEX: begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'b10;
          next_state_s = ADDIWB;
        end
        ADDIWB: begin
          reg_write    = 1'b1;
          retire       = 1'b1;
          next_state_s = FETCH;
        end
        JUMP: begin
          pc_src       = 2'b10;
          pc_en        = 1'b1;
          retire       = 1'b1;
          next_state_s = FETCH;
        end
        default: begin
          next_state_s = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed self-checking bench for multi_cycle_controller: one task per scenario,
// inputs driven on the falling edge and outputs sampled shortly after.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, retire, illegal;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state_debug;

  int errors = 0;
  int checks = 0;

  wire [16:0] out_vec = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                         alu_src_a, alu_src_b, alu_control, pc_src, retire, illegal};

  multi_cycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .pc_src(pc_src), .retire(retire),
    .illegal(illegal), .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b1; opcode = 6'b000000; funct = 6'b100000; zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_vec !== 17'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", out_vec, 17'd0);
    end
    checks++;
    if (state_debug !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", state_debug);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (state_debug !== 4'd0) begin
      errors++; $display("FAIL release_state: got %0d expected 0", state_debug);
    end
    checks++;
    if ({pc_en, ir_write, alu_src_b, alu_control} !== {1'b1, 1'b1, 2'b01, 3'b010}) begin
      errors++; $display("FAIL release_fetch: got %b expected %b",
                         {pc_en, ir_write, alu_src_b, alu_control}, 7'b1101010);
    end
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({pc_en, ir_write} !== 2'b00) begin
      errors++; $display("FAIL fetch_stall_strobes: got %b expected 00", {pc_en, ir_write});
    end
    @(negedge clk);
    #1;
    checks++;
    if (state_debug !== 4'd0) begin
      errors++; $display("FAIL fetch_stall_state: got %0d expected 0", state_debug);
    end
  endtask

  task automatic test_rtype();
    logic [5:0] fn  [0:4];
    logic [2:0] alu [0:4];
    logic [3:0] st  [0:3];
    fn[0] = 6'b100000; alu[0] = 3'b010;
    fn[1] = 6'b100010; alu[1] = 3'b110;
    fn[2] = 6'b100100; alu[2] = 3'b000;
    fn[3] = 6'b100101; alu[3] = 3'b001;
    fn[4] = 6'b101010; alu[4] = 3'b111;
    st[0] = 4'd0; st[1] = 4'd1; st[2] = 4'd6; st[3] = 4'd7;
    for (int i = 0; i < 5; i++) begin
      for (int c = 0; c < 4; c++) begin
        opcode = 6'b000000; funct = fn[i]; mem_ready = 1'b1; zero = 1'b0;
        #1;
        checks++;
        if (state_debug !== st[c]) begin
          errors++; $display("FAIL rtype_state f=%b cyc %0d: got %0d expected %0d", fn[i], c, state_debug, st[c]);
        end
        checks++;
        if ({reg_write, reg_dst, retire} !== {3{c == 3}}) begin
          errors++; $display("FAIL rtype_wb f=%b cyc %0d: got %b expected %b", fn[i], c,
                             {reg_write, reg_dst, retire}, {3{c == 3}});
        end
        checks++;
        if (ir_write !== (c == 0)) begin
          errors++; $display("FAIL rtype_ir_write cyc %0d: got %b expected %b", c, ir_write, c == 0);
        end
        if (c == 2) begin
          checks++;
          if ({alu_control, alu_src_a, alu_src_b} !== {alu[i], 1'b1, 2'b00}) begin
            errors++; $display("FAIL rtype_exec f=%b: got %b expected %b", fn[i],
                               {alu_control, alu_src_a, alu_src_b}, {alu[i], 1'b1, 2'b00});
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_lw();
    logic [3:0] st [0:6];
    logic       mr [0:6];
    st[0] = 4'd0; st[1] = 4'd1; st[2] = 4'd2; st[3] = 4'd3; st[4] = 4'd3; st[5] = 4'd3; st[6] = 4'd4;
    mr[0] = 1'b1; mr[1] = 1'b1; mr[2] = 1'b1; mr[3] = 1'b0; mr[4] = 1'b0; mr[5] = 1'b1; mr[6] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      opcode = 6'b100011; funct = 6'b000000; mem_ready = mr[c]; zero = 1'b0;
      #1;
      checks++;
      if (state_debug !== st[c]) begin
        errors++; $display("FAIL lw_state cyc %0d: got %0d expected %0d", c, state_debug, st[c]);
      end
      checks++;
      if ({mem_to_reg, reg_write, retire} !== {3{c == 6}}) begin
        errors++; $display("FAIL lw_wb cyc %0d: got %b expected %b", c,
                           {mem_to_reg, reg_write, retire}, {3{c == 6}});
      end
      checks++;
      if (iord !== (c >= 3 && c <= 5)) begin
        errors++; $display("FAIL lw_iord cyc %0d: got %b expected %b", c, iord, (c >= 3 && c <= 5));
      end
      if (c == 2) begin
        checks++;
        if ({alu_src_a, alu_src_b, alu_control} !== {1'b1, 2'b10, 3'b010}) begin
          errors++; $display("FAIL lw_memadr: got %b expected 110010", {alu_src_a, alu_src_b, alu_control});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    logic [3:0] st [0:2];
    st[0] = 4'd0; st[1] = 4'd1; st[2] = 4'd8;
    for (int z = 1; z >= 0; z--) begin
      for (int c = 0; c < 3; c++) begin
        opcode = 6'b000100; funct = 6'b000000; mem_ready = 1'b1; zero = 1'(z);
        #1;
        checks++;
        if (state_debug !== st[c]) begin
          errors++; $display("FAIL beq_state z=%0d cyc %0d: got %0d expected %0d", z, c, state_debug, st[c]);
        end
        checks++;
        if (retire !== (c == 2)) begin
          errors++; $display("FAIL beq_retire z=%0d cyc %0d: got %b expected %b", z, c, retire, c == 2);
        end
        if (c == 1) begin
          checks++;
          if ({pc_en, alu_src_b} !== {1'b0, 2'b11}) begin
            errors++; $display("FAIL beq_decode: got %b expected 011", {pc_en, alu_src_b});
          end
        end
        if (c == 2) begin
          checks++;
          if ({pc_en, pc_src, alu_control, alu_src_a} !== {1'(z), 2'b01, 3'b110, 1'b1}) begin
            errors++; $display("FAIL beq_branch z=%0d: got %b expected %b", z,
                               {pc_en, pc_src, alu_control, alu_src_a}, {1'(z), 2'b01, 3'b110, 1'b1});
          end
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_sw();
    logic [3:0] st [0:6];
    logic       mr [0:6];
    st[0] = 4'd0; st[1] = 4'd1; st[2] = 4'd2; st[3] = 4'd5; st[4] = 4'd5; st[5] = 4'd5; st[6] = 4'd5;
    mr[0] = 1'b1; mr[1] = 1'b1; mr[2] = 1'b1; mr[3] = 1'b0; mr[4] = 1'b0; mr[5] = 1'b0; mr[6] = 1'b1;
    for (int c = 0; c < 7; c++) begin
      opcode = 6'b101011; funct = 6'b000000; mem_ready = mr[c]; zero = 1'b0;
      #1;
      checks++;
      if (state_debug !== st[c]) begin
        errors++; $display("FAIL sw_state cyc %0d: got %0d expected %0d", c, state_debug, st[c]);
      end
      checks++;
      if ({mem_write, iord} !== {2{c >= 3}}) begin
        errors++; $display("FAIL sw_strobe cyc %0d: got %b expected %b", c, {mem_write, iord}, {2{c >= 3}});
      end
      checks++;
      if ({retire, reg_write} !== {(c == 6), 1'b0}) begin
        errors++; $display("FAIL sw_retire cyc %0d: got %b expected %b", c, {retire, reg_write}, {(c == 6), 1'b0});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] op [0:6];
    logic [3:0] st [0:6];
    logic [6:0] rt;
    logic [6:0] pe;
    logic [6:0] rw;
    op[0] = 6'b000010; op[1] = 6'b000010; op[2] = 6'b000010;
    op[3] = 6'b001000; op[4] = 6'b001000; op[5] = 6'b001000; op[6] = 6'b001000;
    st[0] = 4'd0; st[1] = 4'd1; st[2] = 4'd11; st[3] = 4'd0; st[4] = 4'd1; st[5] = 4'd9; st[6] = 4'd10;
    rt = 7'b1000100;
    pe = 7'b0001101;
    rw = 7'b1000000;
    for (int c = 0; c < 7; c++) begin
      opcode = op[c]; funct = 6'b000000; mem_ready = 1'b1; zero = 1'b0;
      #1;
      checks++;
      if (state_debug !== st[c]) begin
        errors++; $display("FAIL b2b_state cyc %0d: got %0d expected %0d", c, state_debug, st[c]);
      end
      checks++;
      if ({retire, pc_en, reg_write} !== {rt[c], pe[c], rw[c]}) begin
        errors++; $display("FAIL b2b_ctrl cyc %0d: got %b expected %b", c,
                           {retire, pc_en, reg_write}, {rt[c], pe[c], rw[c]});
      end
      checks++;
      if (32'(reg_write) + 32'(mem_write) + 32'(ir_write) > 32'd1) begin
        errors++; $display("FAIL b2b_strobes cyc %0d: got %b expected at most one", c,
                           {reg_write, mem_write, ir_write});
      end
      if (c == 2) begin
        checks++;
        if (pc_src !== 2'b10) begin
          errors++; $display("FAIL jump_pc_src: got %b expected 10", pc_src);
        end
      end
      if (c == 5) begin
        checks++;
        if ({alu_src_a, alu_src_b, alu_control} !== {1'b1, 2'b10, 3'b010}) begin
          errors++; $display("FAIL addiex: got %b expected 110010", {alu_src_a, alu_src_b, alu_control});
        end
      end
      if (c == 6) begin
        checks++;
        if ({reg_dst, mem_to_reg} !== 2'b00) begin
          errors++; $display("FAIL addiwb_sel: got %b expected 00", {reg_dst, mem_to_reg});
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] op [0:1];
    logic [5:0] fn [0:1];
    logic [3:0] st [0:2];
    op[0] = 6'b111111; fn[0] = 6'b100000;
    op[1] = 6'b000000; fn[1] = 6'b000000;
    st[0] = 4'd0; st[1] = 4'd1; st[2] = 4'd0;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 3; c++) begin
        opcode = op[i]; funct = fn[i]; mem_ready = (c != 2); zero = 1'b0;
        #1;
        checks++;
        if (state_debug !== st[c]) begin
          errors++; $display("FAIL illegal_state case %0d cyc %0d: got %0d expected %0d", i, c, state_debug, st[c]);
        end
        checks++;
        if ({illegal, retire} !== {(c == 1), 1'b0}) begin
          errors++; $display("FAIL illegal_pulse case %0d cyc %0d: got %b expected %b", i, c,
                             {illegal, retire}, {(c == 1), 1'b0});
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] st [0:2];
    st[0] = 4'd0; st[1] = 4'd1; st[2] = 4'd9;
    for (int c = 0; c < 3; c++) begin
      opcode = 6'b001000; funct = 6'b000000; mem_ready = 1'b1; zero = 1'b0;
      #1;
      checks++;
      if (state_debug !== st[c]) begin
        errors++; $display("FAIL mid_state cyc %0d: got %0d expected %0d", c, state_debug, st[c]);
      end
      if (c < 2) @(negedge clk);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({out_vec, state_debug} !== 21'd0) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected 0", {out_vec, state_debug});
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({reg_write, state_debug} !== 5'd0) begin
        errors++; $display("FAIL mid_reset_hold cyc %0d: got %b expected 00000", c, {reg_write, state_debug});
      end
    end
    reset = 1'b1; mem_ready = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({reg_write, state_debug} !== 5'd0) begin
        errors++; $display("FAIL mid_release cyc %0d: got %b expected 00000", c, {reg_write, state_debug});
      end
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0; opcode = 6'b000000; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_sw();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
